tile_spawner: RTL and testbench
===============================

# tile_spawner

Places one new tile on the 4x4 game board after each move, using the pseudo-random cell coordinates and value bit from the LFSR. It sits between the LFSR and the board register file. On each spawn request it snapshots the board and tries random cells until it finds an empty one. After a bounded number of misses it falls back to a deterministic scan. It reports a single write, or reports that the board is full.

## Interface
- `MAX_TRIES`, default 8: number of random samples before falling back to the linear scan; must be ≥1.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `spawn_req` input 1: start request; sampled only in IDLE.
- `board_in` input 64: 16 cells × 4-bit exponent; cell i = `board_in[4i+3:4i]`, i = 4·y + x; exponent 0 means empty.
- `xCoor` input 2: random column from the LFSR; changes every cycle.
- `yCoor` input 2: random row from the LFSR.
- `rndNum` input 1: random value-select bit from the LFSR.
- `busy` output 1: high in every state except IDLE.
- `wr_en` output 1: one-cycle pulse that commits a tile.
- `wr_x` output 2: column of the committed tile.
- `wr_y` output 2: row of the committed tile.
- `wr_val` output 4: exponent of the committed tile (1 = tile 2, 2 = tile 4).
- `done` output 1: one-cycle pulse ending each request.
- `full` output 1: qualifies `done`; high when no empty cell exists.

## Operation
- States: IDLE, SAMPLE, SCAN, RESP.
- IDLE, `spawn_req`=1:
  - latch `board_in` into `board_q`
  - clear try counter and scan index
  - go to SAMPLE.
- SAMPLE, each edge, test `board_q` at cell {`yCoor`,`xCoor`} using the live inputs:
  - empty: register x/y/value, go to RESP
  - occupied and tries = MAX_TRIES−1: go to SCAN
  - occupied otherwise: tries++.
- SCAN, each edge, test `board_q` at `scan_idx` (0..15, ascending):
  - empty: register x = `scan_idx[1:0]`, y = `scan_idx[3:2]`, go to RESP
  - occupied and `scan_idx`=15: set full, go to RESP
  - occupied otherwise: `scan_idx`++.
- RESP, for exactly one cycle:
  - `done`=1
  - `wr_en`=!full
  - `full` as determined
  - `wr_x`/`wr_y`/`wr_val` hold the registered values
  - next state IDLE.
- The snapshot is the only board view used. Changes on `board_in` while busy are ignored, and the parent must not write the board while `busy`.
- `spawn_req` while busy is ignored, not queued. A request held high through RESP starts a new spawn on the first IDLE edge.
- `wr_x`/`wr_y`/`wr_val` are don't-care outside RESP and are driven 0 when `wr_en`=0.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `wr_en`, `done`, `full` = 0
  - `wr_x`, `wr_y` = 0, `wr_val` = 0
  - counters 0.
- All outputs are registered. `busy` rises on the edge that accepts the request (E0) and falls on the edge leaving RESP.
- Edge numbering: E0 is the accepting edge. `done` is high for the cycle after edge Ek.
- Random hit on sample n (1-based): k = n.
- Scan hit at index i: k = MAX_TRIES + i + 1.
- Full board: k = MAX_TRIES + 16 (24 at default).
- Minimum spacing between two `done` pulses: 3 cycles.
- `rst` asserted mid-operation:
  - return to IDLE immediately
  - no `wr_en` or `done` is produced for the aborted request
  - the snapshot is discarded.

## Configuration
- `TILE_SPAWN_FOUR_EN` defined: `wr_val` = `rndNum` ? 2 : 1. The value comes from `rndNum` sampled on the same edge the cell is chosen, in SAMPLE or SCAN.
- Not defined: `wr_val` is always 1, and `rndNum` is unused.

## Test plan
- Empty board, LFSR forced to x=2, y=1, `spawn_req` pulse -> `done` and `wr_en` high one cycle after E1, `wr_x`=2, `wr_y`=1, `full`=0, `busy` then low.
- Full board (all cells exponent 3), default MAX_TRIES -> `done` with `full`=1 and `wr_en`=0 in the cycle after E24; no write.
- Only cell 13 empty, LFSR forced to x=0, y=0 -> 8 misses, then the scan returns `wr_x`=1, `wr_y`=3; `done` after E22.
- Value select, empty board, `rndNum`=1 -> `wr_val`=2 with `TILE_SPAWN_FOUR_EN`, 1 without; with `rndNum`=0, `wr_val`=1 in both builds.
- Full board, assert `rst` at E10 -> all outputs 0 immediately, no `done` afterwards; a new request then completes normally.
- Second `spawn_req` pulse during SCAN, plus `board_in` changed while busy -> ignored; the result reflects the E0 snapshot, and exactly one `done` is produced.

Source files
------------

// File: rtl/tile_spawner.sv
// Spawns one tile on the 4x4 board: random probing of a board snapshot, then a linear scan fallback.
// Optional macro TILE_SPAWN_FOUR_EN lets rndNum select a 4-tile (exponent 2) instead of a 2-tile.
module tile_spawner #(
    parameter int MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic [63:0] board_in,
    input  logic [1:0]  xCoor,
    input  logic [1:0]  yCoor,
    input  logic        rndNum,
    output logic        busy,
    output logic        wr_en,
    output logic [1:0]  wr_x,
    output logic [1:0]  wr_y,
    output logic [3:0]  wr_val,
    output logic        done,
    output logic        full
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, RESP} state_t;

    state_t        state;
    logic [63:0]   board_q;
    logic [TW-1:0] tries;
    logic [3:0]    scan_idx;
    logic [3:0]    sample_idx;
    logic          sample_empty;
    logic          scan_empty;
    logic [3:0]    new_val;

    assign sample_idx   = {yCoor, xCoor};
    assign sample_empty = (board_q[{sample_idx, 2'b00} +: 4] == 4'd0);
    assign scan_empty   = (board_q[{scan_idx, 2'b00} +: 4] == 4'd0);

`ifdef TILE_SPAWN_FOUR_EN
    assign new_val = rndNum ? 4'd2 : 4'd1;
`else
    logic rnd_unused;
    assign rnd_unused = rndNum;
    assign new_val    = 4'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            board_q  <= '0;
            tries    <= '0;
            scan_idx <= '0;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_val   <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        board_q  <= board_in;
                        tries    <= '0;
                        scan_idx <= '0;
                        busy     <= 1'b1;
                        state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (sample_empty) begin
                        wr_x   <= xCoor;
                        wr_y   <= yCoor;
                        wr_val <= new_val;
                        wr_en  <= 1'b1;
                        done   <= 1'b1;
                        full   <= 1'b0;
                        state  <= RESP;
                    end else if (tries == LAST_TRY) begin
                        state <= SCAN;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_empty) begin
                        wr_x   <= scan_idx[1:0];
                        wr_y   <= scan_idx[3:2];
                        wr_val <= new_val;
                        wr_en  <= 1'b1;
                        done   <= 1'b1;
                        full   <= 1'b0;
                        state  <= RESP;
                    end else if (scan_idx == 4'd15) begin
                        full  <= 1'b1;
                        done  <= 1'b1;
                        state <= RESP;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                RESP: begin
                    // write fields return to 0 so they read 0 whenever wr_en is low
                    done   <= 1'b0;
                    wr_en  <= 1'b0;
                    full   <= 1'b0;
                    wr_x   <= '0;
                    wr_y   <= '0;
                    wr_val <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Scoreboard bench for tile_spawner: expected responses are queued at request time, checked on done.
module tb_tile_spawner;

    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spawn_req = 1'b0;
    logic [63:0] board_in = '0;
    logic [1:0]  xCoor = '0;
    logic [1:0]  yCoor = '0;
    logic        rndNum = 1'b0;
    logic        busy, wr_en, done, full;
    logic [1:0]  wr_x, wr_y;
    logic [3:0]  wr_val;

    tile_spawner #(.MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .spawn_req(spawn_req), .board_in(board_in),
        .xCoor(xCoor), .yCoor(yCoor), .rndNum(rndNum), .busy(busy),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
        .done(done), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int x;
        int y;
        int v;
        int f;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: direct hit, else first empty cell in ascending order, else full.
    function automatic exp_t model(input logic [63:0] b, input int x, input int y, input logic rnd);
        exp_t e;
        int   v;
`ifdef TILE_SPAWN_FOUR_EN
        v = rnd ? 2 : 1;
`else
        v = 1;
`endif
        e = '{k: MT + 16, x: 0, y: 0, v: 0, f: 1, acc: 0};
        if (b[(y*4 + x)*4 +: 4] == 4'd0) begin
            e = '{k: 1, x: x, y: y, v: v, f: 0, acc: 0};
        end else begin
            for (int i = 15; i >= 0; i--)
                if (b[i*4 +: 4] == 4'd0) e = '{k: MT + i + 1, x: i % 4, y: i / 4, v: v, f: 0, acc: 0};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                check("spurious_done", int'(done), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("latency", cyc - e.acc, e.k);
                check("wr_en", int'(wr_en), e.f ? 0 : 1);
                check("full", int'(full), e.f);
                check("wr_x", int'(wr_x), e.x);
                check("wr_y", int'(wr_y), e.y);
                check("wr_val", int'(wr_val), e.v);
                check("busy_resp", int'(busy), 1);
            end
        end
    end

    // Issue one request at a negedge, optionally disturbing inputs during SCAN.
    task automatic spawn(input logic [63:0] b, input int x, input int y, input logic rnd,
                         input bit disturb);
        exp_t e;
        int   start;
        bit   got;
        e = model(b, x, y, rnd);
        board_in  = b;
        xCoor     = 2'(x);
        yCoor     = 2'(y);
        rndNum    = rnd;
        e.acc     = cyc + 1;
        sbq.push_back(e);
        start     = done_cnt;
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        check("busy_accept", int'(busy), 1);
        if (disturb) begin
            repeat (MT + 2) @(negedge clk);
            spawn_req = 1'b1;
            board_in  = '0;
            @(negedge clk);
            spawn_req = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk);
            if (done_cnt > start) got = 1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            void'(sbq.pop_front());
        end
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("wr_en_after", int'(wr_en), 0);
        repeat (3) @(negedge clk);
        check("single_done", done_cnt - start, 1);
    endtask

    logic [63:0] b;
    int          start;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_full", int'(full), 0);
        check("rst_wr_val", int'(wr_val), 0);
        rst = 1'b0;
        @(negedge clk);

        spawn('0, 2, 1, 1'b0, 1'b0);
        spawn('0, 3, 0, 1'b1, 1'b0);
        spawn({16{4'd3}}, 1, 2, 1'b0, 1'b0);
        b = {16{4'd3}};
        b[13*4 +: 4] = 4'd0;
        spawn(b, 0, 0, 1'b1, 1'b0);
        b = {16{4'd5}};
        b[0 +: 4] = 4'd0;
        spawn(b, 3, 3, 1'b0, 1'b0);
        b = {16{4'd7}};
        b[15*4 +: 4] = 4'd0;
        spawn(b, 0, 1, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++)
                b[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
            spawn(b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Request and board changes while busy must be ignored.
        b = {16{4'd2}};
        b[5*4 +: 4] = 4'd0;
        spawn(b, 0, 0, 1'b1, 1'b1);

        // Reset in the middle of a full-board request.
        board_in  = {16{4'd3}};
        start     = done_cnt;
        spawn_req = 1'b1;
        @(posedge clk);
        #1 spawn_req = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_full", int'(full), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", done_cnt - start, 0);
        check("abort_idle", int'(busy), 0);
        spawn('0, 1, 3, 1'b0, 1'b0);

        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
